// File: rtl/uart_tx_gen_if.sv
// uart_tx_gen_if: word-in / serial-out port bundle for the UART transmitter.
// Latency: none, plain wires between the word source and the transmitter.
// Backpressure: the source may only count a word as taken when din_vld and rdy are both high.
interface uart_tx_gen_if #(
    parameter int DATA_W = 8
);
    logic              din_vld;
    logic [DATA_W-1:0] din;
    logic              dout;
    logic              rdy;
    logic              busy;

    // Word source side.
    modport master (
        output din_vld,
        output din,
        input  dout,
        input  rdy,
        input  busy
    );

    // Transmitter side.
    modport slave (
        input  din_vld,
        input  din,
        output dout,
        output rdy,
        output busy
    );
endinterface

// File: rtl/uart_tx_gen.sv
// uart_tx_gen: UART serialiser that sends start, DATA_W bits LSB first, optional parity and 1-2 stop bits.
// Latency: dout drops for the start bit on the first clk edge after the accept edge; all outputs are registered.
// Backpressure: rdy low when the word store is full; a din_vld while rdy is low is dropped.
// Build option: define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO, otherwise a single holding register.
module uart_tx_gen #(
    parameter int CLK_DIV    = 2604,
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_tx_gen_if.slave bus
);

    // Reject out-of-range configurations at elaboration.
    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("uart_tx_gen: CLK_DIV must be 2..65535");
    end
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_gen: DATA_W must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_gen: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_gen: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_gen: FIFO_DEPTH must be a power of two in 2..16");
    end

    localparam int                 CNT_W     = $clog2(CLK_DIV);
    localparam int                 IDX_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic               STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              stop_idx_q, stop_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              dout_q, dout_d;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;

    // Word store handshake: push takes din, pop hands the head word to the serialiser.
    logic              push;
    logic              pop;
    logic              pend;
    logic              pend_d;
    logic [DATA_W-1:0] head;
    logic              bit_end;

    assign push    = bus.din_vld && rdy_q;
    assign bit_end = (cnt_q == CNT_LAST);

    // Parity bit that makes data-plus-parity ones odd (PARITY=1) or even (PARITY=2).
    function automatic logic parity_of(input logic [DATA_W-1:0] w);
        if (PARITY == 1) begin
            return ~(^w);
        end
        return ^w;
    endfunction

    // Frame sequencer: picks the next state, the next line level and when to pop a word.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        dout_d     = dout_q;
        pop        = 1'b0;

        // Bit-period timer only runs while a frame is on the line.
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                dout_d = 1'b1;
                if (pend) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    dout_d  = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    dout_d    = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == IDX_LAST) begin
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            dout_d  = par_q;
                        end else begin
                            state_d    = S_STOP;
                            dout_d     = 1'b1;
                            stop_idx_d = 1'b0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        dout_d    = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    dout_d     = 1'b1;
                    stop_idx_d = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_idx_q == STOP_LAST) begin
                        // Chain straight into the next start bit when a word is waiting.
                        if (pend) begin
                            pop     = 1'b1;
                            state_d = S_START;
                            dout_d  = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            dout_d  = 1'b1;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                dout_d  = 1'b1;
            end
        endcase

        // Latch the word and its parity at the moment it leaves the store.
        if (pop) begin
            shift_d = head;
            par_d   = parity_of(head);
            cnt_d   = '0;
        end
    end

`ifdef UART_TX_FIFO_EN
    localparam int             PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    assign pend   = (count_q != '0);
    assign head   = mem_q[rd_ptr_q];
    assign pend_d = (count_d != '0);
    assign rdy_d  = (count_d != FULL);

    // FIFO bookkeeping; a push and pop in the same cycle leave occupancy unchanged.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and occupancy; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
`else
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;

    assign pend   = hold_vld_q;
    assign head   = hold_q;
    assign pend_d = hold_vld_d;
    // Single slot: accept only when fully idle with nothing waiting.
    assign rdy_d  = (state_d == S_IDLE) && !hold_vld_d;

    // Holding register fill and drain.
    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (pop) begin
            hold_vld_d = 1'b0;
        end
        if (push) begin
            hold_d     = bus.din;
            hold_vld_d = 1'b1;
        end
    end

    // Holding register state; reset discards any waiting word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end
`endif

    assign busy_d = (state_d != S_IDLE) || pend_d;

    // Sequencer and output registers; reset drives the line idle-high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            dout_q     <= 1'b1;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            dout_q     <= dout_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.rdy  = rdy_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_uart_tx_gen.sv
// tb_uart_tx_gen: checks four uart_tx_gen configurations against fixed frames and a frame model.
// Latency: frames are sampled every cycle on the falling clock edge, one bit check per bit period.
// Backpressure: exercises dropped writes, FIFO fill (when UART_TX_FIFO_EN is defined) and reset abort.
module tb_uart_tx_gen;
    localparam int NDUT = 4;
    localparam int CDIV [NDUT] = '{16, 4, 4, 4};
    localparam int DW   [NDUT] = '{8, 8, 8, 9};
    localparam int PAR  [NDUT] = '{0, 1, 2, 0};
    localparam int SB   [NDUT] = '{1, 1, 2, 1};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            vld_v [NDUT];
    logic [8:0]      din_v [NDUT];
    logic [NDUT-1:0] dout_v;
    logic [NDUT-1:0] rdy_v;
    logic [NDUT-1:0] busy_v;

    uart_tx_gen_if #(.DATA_W(8)) if0 ();
    uart_tx_gen_if #(.DATA_W(8)) if1 ();
    uart_tx_gen_if #(.DATA_W(8)) if2 ();
    uart_tx_gen_if #(.DATA_W(9)) if3 ();

    assign if0.din_vld = vld_v[0];
    assign if0.din     = din_v[0][7:0];
    assign if1.din_vld = vld_v[1];
    assign if1.din     = din_v[1][7:0];
    assign if2.din_vld = vld_v[2];
    assign if2.din     = din_v[2][7:0];
    assign if3.din_vld = vld_v[3];
    assign if3.din     = din_v[3];
    assign dout_v = {if3.dout, if2.dout, if1.dout, if0.dout};
    assign rdy_v  = {if3.rdy,  if2.rdy,  if1.rdy,  if0.rdy};
    assign busy_v = {if3.busy, if2.busy, if1.busy, if0.busy};

    uart_tx_gen #(.CLK_DIV(16)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    uart_tx_gen #(.CLK_DIV(4), .PARITY(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    uart_tx_gen #(.CLK_DIV(4), .PARITY(2), .STOP_BITS(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    uart_tx_gen #(.CLK_DIV(4), .DATA_W(9)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    int n_err = 0;
    int n_chk = 0;

    bit         exp_q [$];
    int         inj_at = -1;
    logic [8:0] inj_d = '0;
    logic       last_busy;

`ifdef UART_TX_FIFO_EN
    localparam logic RDY_BUSY = 1'b1;
`else
    localparam logic RDY_BUSY = 1'b0;
`endif

    typedef struct {
        int         k;
        logic [8:0] d;
        logic [12:0] f;
        int         n;
    } vec_t;
    vec_t vec [6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, parity from the count of ones, stop ones.
    task automatic push_frame(input int k, input logic [8:0] d);
        int ones;
        ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW[k]; i++) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (PAR[k] == 1) exp_q.push_back(ones % 2 == 0);
        else if (PAR[k] == 2) exp_q.push_back(ones % 2 == 1);
        for (int s = 0; s < SB[k]; s++) exp_q.push_back(1'b1);
    endtask

    // Pulse din_vld for one cycle; the line must not move before the next edge.
    task automatic start_word(input int k, input logic [8:0] d, input string nm);
        @(negedge clk);
        vld_v[k] = 1'b1;
        din_v[k] = d;
        @(negedge clk);
        vld_v[k] = 1'b0;
        check({nm, " dout before start"}, dout_v[k], 1);
        check({nm, " busy after accept"}, busy_v[k], 1);
        check({nm, " rdy after accept"}, rdy_v[k], RDY_BUSY);
    endtask

    // Next falling edge is frame cycle 0; every cycle of every expected bit is compared.
    task automatic check_stream(input int k, input string nm);
        int cyc;
        int bad;
        cyc = 0;
        for (int b = 0; b < exp_q.size(); b++) begin
            bad = 0;
            for (int c = 0; c < CDIV[k]; c++) begin
                @(negedge clk);
                if (dout_v[k] !== exp_q[b]) bad++;
                last_busy = busy_v[k];
                if (cyc == inj_at) begin
                    check({nm, " rdy at extra write"}, rdy_v[k], RDY_BUSY);
                    vld_v[k] = 1'b1;
                    din_v[k] = inj_d;
                end else if (cyc == inj_at + 1) begin
                    vld_v[k] = 1'b0;
                end
                cyc++;
            end
            check($sformatf("%s bit%0d wrong cycles", nm, b), bad, 0);
        end
        inj_at = -1;
    endtask

    task automatic finish_word(input int k, input string nm);
        check({nm, " busy in last stop cycle"}, last_busy, 1);
        @(negedge clk);
        check({nm, " busy falls"}, busy_v[k], 0);
        check({nm, " rdy back"}, rdy_v[k], 1);
        check({nm, " line idle"}, dout_v[k], 1);
    endtask

    task automatic idle_check(input int k, input int n, input string nm);
        int bad;
        bad = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (dout_v[k] !== 1'b1 || busy_v[k] !== 1'b0) bad++;
        end
        check(nm, bad, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal;
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            vld_v[k] = 1'b0;
            din_v[k] = '0;
        end
        // Hand-derived frames, bit i = i-th bit on the line.
        vec[0] = '{0, 9'h005, 13'h020A, 10};
        vec[1] = '{1, 9'h007, 13'h040E, 11};
        vec[2] = '{2, 9'h007, 13'h0E0E, 12};
        vec[3] = '{3, 9'h1AB, 13'h0756, 11};
        vec[4] = '{0, 9'h0FF, 13'h03FE, 10};
        vec[5] = '{1, 9'h000, 13'h0600, 11};

        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("reset dout%0d", k), dout_v[k], 1);
            check($sformatf("reset rdy%0d", k), rdy_v[k], 0);
            check($sformatf("reset busy%0d", k), busy_v[k], 0);
        end
        rst_n = 1'b1;
        #1;
        check("rdy before first edge", rdy_v[0], 0);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) check($sformatf("rdy after release%0d", k), rdy_v[k], 1);

        // Fixed vectors.
        for (int t = 0; t < 6; t++) begin
            exp_q.delete();
            for (int i = 0; i < vec[t].n; i++) exp_q.push_back(vec[t].f[i]);
            start_word(vec[t].k, vec[t].d, $sformatf("vec%0d", t));
            check_stream(vec[t].k, $sformatf("vec%0d", t));
            finish_word(vec[t].k, $sformatf("vec%0d", t));
        end

        // Extra write mid-frame: dropped with a holding register, queued with a FIFO.
        exp_q.delete();
        push_frame(0, 9'h005);
`ifdef UART_TX_FIFO_EN
        push_frame(0, 9'h03C);
`endif
        inj_at = 30;
        inj_d  = 9'h03C;
        start_word(0, 9'h005, "midwrite");
        check_stream(0, "midwrite");
        finish_word(0, "midwrite");
        idle_check(0, 32, "midwrite no extra frame");

`ifdef UART_TX_FIFO_EN
        // Five back-to-back writes into a depth-4 FIFO: all accepted, then full.
        exp_q.delete();
        for (int w = 5; w <= 9; w++) push_frame(0, 9'(w));
        fork
            begin
                for (int w = 5; w <= 9; w++) begin
                    @(negedge clk);
                    vld_v[0] = 1'b1;
                    din_v[0] = 9'(w);
                end
                @(negedge clk);
                vld_v[0] = 1'b0;
                check("fifo full rdy", rdy_v[0], 0);
            end
            begin
                repeat (2) @(negedge clk);
                check_stream(0, "fifo burst");
            end
        join
        finish_word(0, "fifo burst");
`endif

        // Reset in the middle of a frame, with an extra word offered beforehand.
        start_word(0, 9'h055, "abort");
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (c == 20) begin
                vld_v[0] = 1'b1;
                din_v[0] = 9'h0AA;
            end else if (c == 21) begin
                vld_v[0] = 1'b0;
            end
        end
        check("abort dout before reset", dout_v[0], 0);
        rst_n = 1'b0;
        #1;
        check("abort dout async", dout_v[0], 1);
        check("abort busy", busy_v[0], 0);
        check("abort rdy", rdy_v[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort rdy after release", rdy_v[0], 1);
        idle_check(0, 48, "abort queue flushed");
        exp_q.delete();
        push_frame(0, 9'h0C3);
        start_word(0, 9'h0C3, "after abort");
        check_stream(0, "after abort");
        finish_word(0, "after abort");

        // Random words on random configurations.
        for (int r = 0; r < 12; r++) begin
            int         kk;
            logic [8:0] dd;
            kk = int'($urandom_range(0, NDUT - 1));
            dd = 9'($urandom_range(0, (1 << DW[kk]) - 1));
            exp_q.delete();
            push_frame(kk, dd);
            start_word(kk, dd, $sformatf("rand%0d", r));
            check_stream(kk, $sformatf("rand%0d", r));
            finish_word(kk, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_tx_gen.md
UART_TX_GEN -- requirements
Module: uart_tx_gen

Interface
REQ-001 Parameter CLK_DIV, default 2604, clk cycles per bit (50 MHz -> 19200 baud); legal range 2..65535.
REQ-002 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0, parity mode: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-006 clk  input  1  single system clock; all logic is on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 din_vld  input  1  write strobe for din.
REQ-009 din  input  DATA_W  data word to transmit, LSB first.
REQ-010 dout  output  1  serial line, idle high.
REQ-011 rdy  output  1  block can accept a word this cycle.
REQ-012 busy  output  1  frame in progress or word pending.

Function
REQ-013 A word is accepted only in a cycle where din_vld=1 and rdy=1; din_vld while rdy=0 is ignored (word dropped, no state change).
REQ-014 Frame order: start bit (0), DATA_W data bits LSB first, parity bit if PARITY!=0, then STOP_BITS stop bits (1); every bit lasts exactly CLK_DIV cycles.
REQ-015 Parity: odd makes the total count of ones in data plus parity odd; even makes it even; computed from the word as stored at acceptance.
REQ-016 Latency: when idle, dout falls to 0 on the first rising edge after the acceptance edge; dout is registered (no combinational path from din/din_vld).
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0; STOP runs for STOP_BITS bit periods.
REQ-018 In STOP, at the end of the last stop-bit period, go to START without an idle cycle if a word is pending, else go to IDLE.
REQ-019 The bit-period counter counts 0..CLK_DIV-1 and wraps; the bit index counts 0..DATA_W-1 in DATA.
REQ-020 busy=1 from the acceptance edge until the last stop bit completes with nothing pending.
REQ-021 Simultaneous accept and dequeue in the same cycle are both honoured; occupancy is unchanged.

Reset
REQ-022 While rst_n=0: dout=1, rdy=0, busy=0, FSM=IDLE, all counters 0, FIFO/holding register empty.
REQ-023 rst_n asserted mid-frame aborts the frame immediately; dout=1 asynchronously; pending words are discarded.
REQ-024 rdy goes to 1 on the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro UART_TX_FIFO_EN defined: a FIFO_DEPTH-entry FIFO buffers words; rdy=1 whenever the FIFO is not full, including mid-frame.
REQ-026 UART_TX_FIFO_EN undefined: a single holding register replaces the FIFO; rdy=1 only in IDLE with no pending word; rdy=0 from the acceptance edge until the block returns to IDLE; FIFO_DEPTH is ignored.

Verification
REQ-027 Defaults, CLK_DIV=16, din=8'h05 pulsed one cycle -> dout frame 0,1,0,1,0,0,0,0,0,1, each bit 16 cycles; start begins 1 cycle after the accept; busy falls after 160 cycles.
REQ-028 PARITY=1, din=8'h07 -> parity bit 0; PARITY=2, din=8'h07 -> parity bit 1; STOP_BITS=2 -> stop high for 32 cycles.
REQ-029 FIFO_EN, depth 4: write 8'h05..8'h09 on consecutive cycles -> first five accepted, rdy=0 after the FIFO fills; frames back-to-back with no idle gap; bytes 5,6,7,8,9 in order.
REQ-030 FIFO_EN undefined: second din_vld during a frame -> rdy=0, word dropped; only the first byte is transmitted.
REQ-031 rst_n pulled low at cycle 40 of a frame -> dout=1 immediately, busy=0, queued words lost; a new word after release transmits correctly.
REQ-032 DATA_W=9, din=9'h1AB -> 9 data bits LSB first; total frame 11 bits at 1 stop bit, PARITY=0.
